mem_access_unit_multi: RTL and testbench

Parametrised multicycle load/store unit for the RISC-V multicycle core. It replaces the combinational load/store byte-lane logic and the "previous ALU result" alignment register with a self-contained sequencer. Accepts one load/store request from the control FSM, drives the data bus with a ready/error handshake, splits beat-crossing misaligned accesses into two bus beats, and returns sign/zero-extended load data or an exception code.

---
 rtl/mem_access_unit_multi.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit_multi.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_multi.sv
// Multicycle load/store sequencer: one request, one or two bus beats, extended load data or exception code.
// Latency: aligned oDone 2 cycles after iStart, beat-crossing 3, plus one per bus wait cycle.
// Backpressure: each beat is held stable until iBusReady; iStart is ignored while oBusy.
module mem_access_unit_multi #(
    parameter int XLEN             = 32,
    parameter int ALLOW_MISALIGNED = 1,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic              iIsStore,
    input  logic [2:0]        iFunct3,
    input  logic [XLEN-1:0]   iAddress,
    input  logic [XLEN-1:0]   iStoreData,
    output logic              oBusy,
    output logic              oDone,
    output logic [XLEN-1:0]   oLoadData,
    output logic              oExcValid,
    output logic [4:0]        oExcCode,
    output logic [XLEN-1:0]   oBusAddress,
    output logic [XLEN-1:0]   oBusWriteData,
    output logic [XLEN/8-1:0] oBusByteEnable,
    output logic              oBusWriteEnable,
    output logic              oBusReadEnable,
    input  logic [XLEN-1:0]   iBusReadData,
    input  logic              iBusReady,
    input  logic              iBusError
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, DONE, EXC} state_t;

    state_t            state, state_d;
    logic              is_store_q, split_q;
    logic [2:0]        f3_q;
    logic [OW-1:0]     off_q;
    logic [XLEN-1:0]   base_q, sdata_q, lo_q, load_q;
    logic [TW-1:0]     cnt_q;
    logic [4:0]        exc_q, exc_d;

    logic [3:0]        sz_bytes, sz_q_bytes;
    logic [OW-1:0]     off_in;
    logic              illegal, misal, split, wrap, in_beat, hi_beat, timeout;
    logic [4:0]        fault_code;
    logic [2*XLEN-1:0] rd_wide, st_wide;
    logic [XLEN-1:0]   rd_raw, ld_mask, ld_ext;
    logic              ld_sign;
    logic [2*NB-1:0]   be_wide;

    assign sz_bytes = 4'd1 << iFunct3[1:0];
    assign off_in   = iAddress[OW-1:0];
    assign illegal  = (iFunct3 == 3'b111) || (iIsStore && iFunct3[2]) ||
                      ((XLEN == 32) && ((iFunct3[1:0] == 2'b11) || (iFunct3 == 3'b110)));
    assign misal    = |(4'(off_in) & (sz_bytes - 4'd1));
    assign split    = (5'(off_in) + 5'(sz_bytes)) > 5'(NB);
    assign wrap     = &iAddress[XLEN-1:OW];

    assign in_beat    = (state == BEAT1) || (state == BEAT2);
    assign hi_beat    = (state == BEAT2);
    assign timeout    = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
    assign fault_code = is_store_q ? 5'd7 : 5'd5;

    always_comb begin
        state_d = state;
        exc_d   = exc_q;
        case (state)
            IDLE: begin
                if (iStart) begin
                    if (illegal) begin
                        state_d = EXC;
                        exc_d   = 5'd2;
                    end else if (misal && (ALLOW_MISALIGNED == 0)) begin
                        state_d = EXC;
                        exc_d   = iIsStore ? 5'd6 : 5'd4;
                    end else if (split && wrap) begin
                        // second beat would wrap the address space: fault before touching the bus
                        state_d = EXC;
                        exc_d   = iIsStore ? 5'd7 : 5'd5;
                    end else begin
                        state_d = BEAT1;
                    end
                end
            end
            BEAT1, BEAT2: begin
                if (iBusReady) begin
                    if (iBusError) begin
                        state_d = EXC;
                        exc_d   = fault_code;
                    end else if ((state == BEAT1) && split_q) begin
                        state_d = BEAT2;
                    end else begin
                        state_d = DONE;
                    end
                end else if (timeout) begin
                    state_d = EXC;
                    exc_d   = fault_code;
                end
            end
            DONE, EXC: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Load path: the final beat arrives combinationally, so extraction runs off the live bus data.
    assign rd_wide = hi_beat ? {iBusReadData, lo_q} : {{XLEN{1'b0}}, iBusReadData};
    assign rd_raw  = XLEN'(rd_wide >> {off_q, 3'b000});

    always_comb begin
        ld_mask = '1;
        ld_sign = rd_raw[XLEN-1];
        case (f3_q[1:0])
            2'b00: begin ld_mask = XLEN'(8'hFF);          ld_sign = rd_raw[7];  end
            2'b01: begin ld_mask = XLEN'(16'hFFFF);       ld_sign = rd_raw[15]; end
            2'b10: begin ld_mask = XLEN'(32'hFFFF_FFFF);  ld_sign = rd_raw[31]; end
            default: begin ld_mask = '1;                  ld_sign = rd_raw[XLEN-1]; end
        endcase
        ld_ext = (!f3_q[2] && ld_sign) ? (rd_raw | ~ld_mask) : (rd_raw & ld_mask);
    end

    assign sz_q_bytes = 4'd1 << f3_q[1:0];
    assign st_wide    = {{XLEN{1'b0}}, sdata_q} << {off_q, 3'b000};
    assign be_wide    = (((2*NB)'(1) << sz_q_bytes) - (2*NB)'(1)) << off_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= IDLE;
            exc_q      <= '0;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            split_q    <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            base_q     <= '0;
            sdata_q    <= '0;
            lo_q       <= '0;
            load_q     <= '0;
        end else begin
            state <= state_d;
            exc_q <= exc_d;
            cnt_q <= (in_beat && (state_d == state)) ? cnt_q + TW'(1) : '0;
            if ((state == IDLE) && iStart) begin
                is_store_q <= iIsStore;
                split_q    <= split;
                f3_q       <= iFunct3;
                off_q      <= off_in;
                base_q     <= {iAddress[XLEN-1:OW], {OW{1'b0}}};
                sdata_q    <= iStoreData;
            end
            if ((state == BEAT1) && iBusReady && !iBusError)
                lo_q <= iBusReadData;
            if ((state_d == DONE) && !is_store_q)
                load_q <= ld_ext;
        end
    end

    assign oBusy           = (state != IDLE);
    assign oDone           = (state == DONE);
    assign oExcValid       = (state == EXC);
    assign oExcCode        = oExcValid ? exc_q : 5'd0;
    assign oLoadData       = load_q;
    assign oBusAddress     = in_beat ? (hi_beat ? base_q + XLEN'(NB) : base_q) : '0;
    assign oBusWriteData   = in_beat ? (hi_beat ? st_wide[2*XLEN-1:XLEN] : st_wide[XLEN-1:0]) : '0;
    assign oBusByteEnable  = in_beat ? (hi_beat ? be_wide[2*NB-1:NB] : be_wide[NB-1:0]) : '0;
    assign oBusWriteEnable = in_beat && is_store_q;
    assign oBusReadEnable  = in_beat && !is_store_q;
endmodule

// File: tb/tb_mem_access_unit_multi.sv
// Bench for mem_access_unit_multi: directed vector table, hand sequences and random accesses vs a byte-level memory model.
module tb_mem_access_unit_multi;
    logic        iCLK = 1'b0;
    logic        iRST, iStart, iIsStore;
    logic [2:0]  iFunct3;
    logic [31:0] iAddress, iStoreData;
    logic        oBusy, oDone, oExcValid, oBusWriteEnable, oBusReadEnable;
    logic [4:0]  oExcCode;
    logic [31:0] oLoadData, oBusAddress, oBusWriteData;
    logic [3:0]  oBusByteEnable;
    logic [31:0] iBusReadData = '0;
    logic        iBusReady = 1'b0, iBusError = 1'b0;

    logic        n_busy, n_done, n_exc, n_we, n_re;
    logic [4:0]  n_code;
    logic [31:0] n_ld, n_addr, n_wdata;
    logic [3:0]  n_be;
    logic [31:0] n_rdata = '0;
    logic        n_ready = 1'b1, n_err = 1'b0;

    mem_access_unit_multi #(.XLEN(32), .ALLOW_MISALIGNED(1), .TIMEOUT_CYCLES(8)) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iIsStore(iIsStore), .iFunct3(iFunct3),
        .iAddress(iAddress), .iStoreData(iStoreData), .oBusy(oBusy), .oDone(oDone),
        .oLoadData(oLoadData), .oExcValid(oExcValid), .oExcCode(oExcCode),
        .oBusAddress(oBusAddress), .oBusWriteData(oBusWriteData), .oBusByteEnable(oBusByteEnable),
        .oBusWriteEnable(oBusWriteEnable), .oBusReadEnable(oBusReadEnable),
        .iBusReadData(iBusReadData), .iBusReady(iBusReady), .iBusError(iBusError));

    mem_access_unit_multi #(.XLEN(32), .ALLOW_MISALIGNED(0), .TIMEOUT_CYCLES(8)) dut_na (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iIsStore(iIsStore), .iFunct3(iFunct3),
        .iAddress(iAddress), .iStoreData(iStoreData), .oBusy(n_busy), .oDone(n_done),
        .oLoadData(n_ld), .oExcValid(n_exc), .oExcCode(n_code),
        .oBusAddress(n_addr), .oBusWriteData(n_wdata), .oBusByteEnable(n_be),
        .oBusWriteEnable(n_we), .oBusReadEnable(n_re),
        .iBusReadData(n_rdata), .iBusReady(n_ready), .iBusError(n_err));

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Bus slave: byte memory, configurable wait states per beat, optional error on the ready beat.
    logic [7:0]  bus_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    int          resp_wait = 0;
    logic        resp_err  = 1'b0;
    int          wcnt      = 0;
    logic        rdy_prev  = 1'b0;
    logic [31:0] last_addr = '0, last_wdata = '0;
    logic [3:0]  last_be   = '0;

    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
    endfunction

    always @(negedge iCLK) begin
        logic strobe;
        strobe = oBusWriteEnable | oBusReadEnable;
        if (!strobe || rdy_prev) wcnt = 0;
        iBusReady    = 1'b0;
        iBusError    = 1'b0;
        iBusReadData = '0;
        if (strobe) begin
            if (wcnt >= resp_wait) begin
                iBusReady  = 1'b1;
                iBusError  = resp_err;
                last_addr  = oBusAddress;
                last_wdata = oBusWriteData;
                last_be    = oBusByteEnable;
                for (int i = 0; i < 4; i++) begin
                    iBusReadData[8*i +: 8] = bus_rd(oBusAddress + 32'(i));
                    if (oBusWriteEnable && !resp_err && oBusByteEnable[i])
                        bus_mem[oBusAddress + 32'(i)] = oBusWriteData[8*i +: 8];
                end
            end else begin
                wcnt++;
            end
        end
        rdy_prev = iBusReady;
    end

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bus_mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    // Starts one request just after a negedge and watches both instances until they finish.
    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                             input int waits, input logic err,
                             output int cyc, output int kind, output logic [4:0] code, output logic [31:0] ld,
                             output int na_cyc, output int na_kind, output logic [4:0] na_code,
                             output int na_strb, output int we_cyc);
        resp_wait = waits;
        resp_err  = err;
        iIsStore = st; iFunct3 = f3; iAddress = addr; iStoreData = sdata; iStart = 1'b1;
        cyc = 0; kind = 0; code = '0; ld = '0;
        na_cyc = 0; na_kind = 0; na_code = '0; na_strb = 0; we_cyc = 0;
        @(negedge iCLK);
        iStart = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (kind == 0) begin
                if (oBusWriteEnable) we_cyc++;
                if (oDone || oExcValid) begin
                    cyc = n; kind = oDone ? 1 : 2; code = oExcCode; ld = oLoadData;
                end
            end
            if (na_kind == 0) begin
                if (n_we || n_re) na_strb++;
                if (n_done || n_exc) begin
                    na_cyc = n; na_kind = n_done ? 1 : 2; na_code = n_code;
                end
            end
            if (kind != 0 && na_kind != 0) break;
            @(negedge iCLK);
        end
        @(negedge iCLK);
        resp_wait = 0;
        resp_err  = 1'b0;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          waits;
        logic        err;
        int          exp_cyc;
        int          exp_kind;   // 1 done, 2 exception
        logic [4:0]  exp_code;
        logic [31:0] exp_ld;
    } vec_t;

    vec_t vt [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int cyc, kind, na_cyc, na_kind, na_strb, we_cyc;
        logic [4:0] code, na_code;
        logic [31:0] ld;
        logic [2:0] ld_ops [5];

        iRST = 1'b1; iStart = 1'b0; iIsStore = 1'b0; iFunct3 = '0; iAddress = '0; iStoreData = '0;
        put_word(32'h100, 32'hDEADBEEF);
        put_word(32'h200, 32'h80123456);
        put_word(32'h300, 32'h55667788);
        put_word(32'h304, 32'h11223344);
        put_word(32'h308, 32'hA5A5A5A5);

        repeat (2) @(negedge iCLK);
        chk("reset busy", oBusy, 0);
        chk("reset done", oDone, 0);
        chk("reset exc", oExcValid, 0);
        chk("reset loaddata", oLoadData, 0);
        chk("reset be", oBusByteEnable, 0);
        iRST = 1'b0;
        @(negedge iCLK);

        //        st    f3      addr          sdata  waits err  cyc kind code  ld
        vt[0]  = '{1'b0, 3'b010, 32'h100,      '0,    0,    0,   2,  1,   0,  32'hDEADBEEF};
        vt[1]  = '{1'b0, 3'b000, 32'h203,      '0,    0,    0,   2,  1,   0,  32'hFFFFFF80};
        vt[2]  = '{1'b0, 3'b100, 32'h203,      '0,    0,    0,   2,  1,   0,  32'h00000080};
        vt[3]  = '{1'b0, 3'b010, 32'h302,      '0,    0,    0,   3,  1,   0,  32'h33445566};
        vt[4]  = '{1'b0, 3'b001, 32'h307,      '0,    0,    0,   3,  1,   0,  32'hFFFFA511};
        vt[5]  = '{1'b0, 3'b111, 32'h100,      '0,    0,    0,   1,  2,   2,  32'hFFFFA511};
        vt[6]  = '{1'b1, 3'b100, 32'h100,      '0,    0,    0,   1,  2,   2,  32'hFFFFA511};
        vt[7]  = '{1'b0, 3'b011, 32'h100,      '0,    0,    0,   1,  2,   2,  32'hFFFFA511};
        vt[8]  = '{1'b0, 3'b110, 32'h100,      '0,    0,    0,   1,  2,   2,  32'hFFFFA511};
        vt[9]  = '{1'b0, 3'b010, 32'h100,      '0,    3,    1,   5,  2,   5,  32'hFFFFA511};
        vt[10] = '{1'b1, 3'b010, 32'h400,      '1,    0,    1,   2,  2,   7,  32'hFFFFA511};
        vt[11] = '{1'b0, 3'b010, 32'hFFFFFFFE, '0,    0,    0,   1,  2,   5,  32'hFFFFA511};
        vt[12] = '{1'b0, 3'b101, 32'h302,      '0,    2,    0,   4,  1,   0,  32'h00005566};
        vt[13] = '{1'b0, 3'b010, 32'h100,      '0,    1000, 0,   9,  2,   5,  32'h00005566};

        for (int i = 0; i < 14; i++) begin
            do_access(vt[i].st, vt[i].f3, vt[i].addr, vt[i].sdata, vt[i].waits, vt[i].err,
                      cyc, kind, code, ld, na_cyc, na_kind, na_code, na_strb, we_cyc);
            chk($sformatf("vec%0d kind", i), kind, vt[i].exp_kind);
            chk($sformatf("vec%0d cycle", i), cyc, vt[i].exp_cyc);
            chk($sformatf("vec%0d loaddata", i), ld, vt[i].exp_ld);
            if (vt[i].exp_kind == 2) chk($sformatf("vec%0d code", i), code, vt[i].exp_code);
        end
        chk("faulted store not written", bus_mem.exists(32'h400), 0);

        // Halfword store into the upper lanes
        do_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 1'b0,
                  cyc, kind, code, ld, na_cyc, na_kind, na_code, na_strb, we_cyc);
        chk("sh kind", kind, 1);
        chk("sh cycle", cyc, 2);
        chk("sh be", last_be, 4'b1100);
        chk("sh wdata hi", last_wdata[31:16], 16'hABCD);
        chk("sh addr", last_addr, 32'h100);
        chk("sh we cycles", we_cyc, 1);
        chk("sh mem 0x102", bus_rd(32'h102), 8'hCD);
        chk("sh mem 0x103", bus_rd(32'h103), 8'hAB);

        // Misaligned accesses with splitting disabled never reach the bus
        do_access(1'b0, 3'b010, 32'h102, '0, 0, 1'b0,
                  cyc, kind, code, ld, na_cyc, na_kind, na_code, na_strb, we_cyc);
        chk("na lw kind", na_kind, 2);
        chk("na lw cycle", na_cyc, 1);
        chk("na lw code", na_code, 4);
        chk("na lw strobes", na_strb, 0);
        chk("split lw cycle", cyc, 3);
        do_access(1'b1, 3'b001, 32'h501, 32'h0000BEEF, 0, 1'b0,
                  cyc, kind, code, ld, na_cyc, na_kind, na_code, na_strb, we_cyc);
        chk("na sh kind", na_kind, 2);
        chk("na sh code", na_code, 6);
        chk("na sh strobes", na_strb, 0);

        // Reset mid-store: bus strobes drop without waiting for a clock edge
        resp_wait = 1000;
        iIsStore = 1'b1; iFunct3 = 3'b010; iAddress = 32'h600; iStoreData = 32'h0BADF00D; iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        chk("pre-reset we", oBusWriteEnable, 1);
        chk("pre-reset be", oBusByteEnable, 4'b1111);
        #2 iRST = 1'b1;
        #1;
        chk("async reset we", oBusWriteEnable, 0);
        chk("async reset busy", oBusy, 0);
        chk("async reset be", oBusByteEnable, 0);
        @(negedge iCLK);
        iRST = 1'b0;
        resp_wait = 0;
        @(negedge iCLK);
        chk("reset store not written", bus_mem.exists(32'h600), 0);
        do_access(1'b0, 3'b010, 32'h100, '0, 0, 1'b0,
                  cyc, kind, code, ld, na_cyc, na_kind, na_code, na_strb, we_cyc);
        chk("post-reset lw kind", kind, 1);
        chk("post-reset lw cycle", cyc, 2);
        chk("post-reset lw data", ld, 32'hABCDBEEF);

        // Random accesses against a byte-array reference memory
        ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int a = 32'h1000; a < 32'h1044; a++) begin
            logic [7:0] b;
            b = 8'($urandom);
            bus_mem[32'(a)] = b;
            ref_mem[32'(a)] = b;
        end
        for (int t = 0; t < 150; t++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] addr, sdata, exp;
            int          sz, w, beats;
            st    = 1'($urandom);
            f3    = st ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
            addr  = 32'h1000 + 32'($urandom_range(0, 59));
            sdata = $urandom;
            w     = $urandom_range(0, 2);
            sz    = 1 << f3[1:0];
            beats = (int'(addr % 4) + sz > 4) ? 2 : 1;
            exp   = '0;
            if (st) begin
                for (int i = 0; i < sz; i++) ref_mem[addr + 32'(i)] = sdata[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) exp[8*i +: 8] = ref_mem[addr + 32'(i)];
                if (sz < 4 && !f3[2] && exp[8*sz-1])
                    for (int b = 8*sz; b < 32; b++) exp[b] = 1'b1;
            end
            do_access(st, f3, addr, sdata, w, 1'b0,
                      cyc, kind, code, ld, na_cyc, na_kind, na_code, na_strb, we_cyc);
            chk($sformatf("rnd%0d kind", t), kind, 1);
            chk($sformatf("rnd%0d cycle", t), cyc, beats * (w + 1) + 1);
            if (!st) chk($sformatf("rnd%0d f3=%0d addr=%0h loaddata", t, f3, addr), ld, exp);
        end
        for (int a = 32'h1000; a < 32'h1044; a++)
            chk($sformatf("rnd mem %0h", a), bus_rd(32'(a)), ref_mem[32'(a)]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
